// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - two-pipe right-to-left scroller with gap latching and scoring
module pipe_scroller #(
    parameter int SCREEN_W = 640,
    parameter int SPACING  = 320,
    parameter int SPEED    = 2,
    parameter int TICK_DIV = 65536,
    parameter int BIRD_X   = 160,
    parameter int GAP_RST  = 100
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        hit,
    input  logic        restart,
    input  logic [15:0] gap1_in,
    input  logic [15:0] gap2_in,
    output logic [15:0] pipe_pos1,
    output logic [15:0] pipe_pos2,
    output logic [15:0] gap1,
    output logic [15:0] gap2,
    output logic [15:0] score,
    output logic        score_pls,
    output logic        running
);

    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0] P_SCREEN_W = 16'(SCREEN_W);
    localparam logic [15:0] P_POS2_RST = 16'(SCREEN_W + SPACING);
    localparam logic [15:0] P_SPEED    = 16'(SPEED);
    localparam logic [15:0] P_BIRD_X   = 16'(BIRD_X);
    localparam logic [15:0] P_GAP_RST  = 16'(GAP_RST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_pos1;
    logic [15:0]   r_pos2;
    logic [15:0]   r_gap1;
    logic [15:0]   r_gap2;
    logic [15:0]   r_score;
    logic          r_score_pls;
    logic          r_running;

    logic          w_tick;
    logic          w_step;
    logic          w_reload;
    logic [15:0]   w_new_pos1;
    logic [15:0]   w_new_pos2;
    logic          w_pass1;
    logic          w_pass2;
    logic [16:0]   w_sum;
    logic [15:0]   w_score_sat;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_reload     = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_RUN;
            S_RUN:  if (hit)   w_next_state = S_DEAD;
            S_DEAD: begin
                if (restart) begin
                    w_next_state = S_IDLE;
                    w_reload     = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_tick = (r_presc == PRESC_MAX);
    // a hit on the tick cycle suppresses the step entirely
    assign w_step = (r_state == S_RUN) && !hit && w_tick;

    assign w_new_pos1 = (r_pos1 == 16'd0) ? P_SCREEN_W : r_pos1 - P_SPEED;
    assign w_new_pos2 = (r_pos2 == 16'd0) ? P_SCREEN_W : r_pos2 - P_SPEED;
    assign w_pass1    = (w_new_pos1 == P_BIRD_X);
    assign w_pass2    = (w_new_pos2 == P_BIRD_X);

    assign w_sum       = {1'b0, r_score} + 17'(w_pass1) + 17'(w_pass2);
    assign w_score_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_presc     <= '0;
            r_pos1      <= P_SCREEN_W;
            r_pos2      <= P_POS2_RST;
            r_gap1      <= P_GAP_RST;
            r_gap2      <= P_GAP_RST;
            r_score     <= 16'd0;
            r_score_pls <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_running   <= (r_state == S_RUN);
            r_score_pls <= 1'b0;
            if (r_state == S_RUN && !hit && !w_tick) begin
                r_presc <= r_presc + 1'b1;
            end else begin
                r_presc <= '0;
            end
            if (w_reload) begin
                r_pos1  <= P_SCREEN_W;
                r_pos2  <= P_POS2_RST;
                r_gap1  <= P_GAP_RST;
                r_gap2  <= P_GAP_RST;
                r_score <= 16'd0;
            end else if (w_step) begin
                r_pos1 <= w_new_pos1;
                r_pos2 <= w_new_pos2;
                if (r_pos1 == 16'd0) r_gap1 <= gap1_in;
                if (r_pos2 == 16'd0) r_gap2 <= gap2_in;
                if (w_pass1 || w_pass2) begin
                    r_score     <= w_score_sat;
                    r_score_pls <= 1'b1;
                end
            end
        end
    end

    assign pipe_pos1 = r_pos1;
    assign pipe_pos2 = r_pos2;
    assign gap1      = r_gap1;
    assign gap2      = r_gap2;
    assign score     = r_score;
    assign score_pls = r_score_pls;
    assign running   = r_running;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - randomized check of pipe_scroller against a behavioural model
module tb_pipe_scroller;

    localparam int SW  = 16;
    localparam int SP  = 8;
    localparam int SPD = 2;
    localparam int TD  = 4;
    localparam int BX  = 6;
    localparam int GR  = 100;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start, hit, restart;
    logic [15:0] gap1_in, gap2_in;
    logic [15:0] pipe_pos1, pipe_pos2, gap1, gap2, score;
    logic        score_pls, running;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 idle, 1 run, 2 dead
    int m_state, m_presc, m_pos1, m_pos2, m_gap1, m_gap2, m_score, m_pls, m_running;

    pipe_scroller #(
        .SCREEN_W(SW), .SPACING(SP), .SPEED(SPD),
        .TICK_DIV(TD), .BIRD_X(BX), .GAP_RST(GR)
    ) dut (
        .clk(clk), .Reset(Reset), .start(start), .hit(hit), .restart(restart),
        .gap1_in(gap1_in), .gap2_in(gap2_in),
        .pipe_pos1(pipe_pos1), .pipe_pos2(pipe_pos2), .gap1(gap1), .gap2(gap2),
        .score(score), .score_pls(score_pls), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_pos1 = SW; m_pos2 = SW + SP;
        m_gap1 = GR; m_gap2 = GR; m_score = 0; m_pls = 0; m_running = 0;
    endtask

    function automatic int advance(input int p);
        return (p == 0) ? SW : p - SPD;
    endfunction

    task automatic model_edge();
        int passes;
        m_running = (m_state == 1);
        m_pls = 0;
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                if (hit) begin
                    m_state = 2;
                    m_presc = 0;
                end else if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (m_pos1 == 0) m_gap1 = gap1_in;
                    if (m_pos2 == 0) m_gap2 = gap2_in;
                    m_pos1 = advance(m_pos1);
                    m_pos2 = advance(m_pos2);
                    passes = (m_pos1 == BX ? 1 : 0) + (m_pos2 == BX ? 1 : 0);
                    if (passes > 0) begin
                        m_score = (m_score + passes > 65535) ? 65535 : m_score + passes;
                        m_pls = 1;
                    end
                end else begin
                    m_presc++;
                end
            end
            default: begin
                if (restart) begin
                    model_reset();
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("pos1", pipe_pos1, m_pos1);
        check("pos2", pipe_pos2, m_pos2);
        check("gap1", gap1, m_gap1);
        check("gap2", gap2, m_gap2);
        check("score", score, m_score);
        check("score_pls", score_pls, m_pls);
        check("running", running, m_running);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic mid_reset();
        #3 Reset = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; hit = 1'b0; restart = 1'b0;
        gap1_in = 16'd0; gap2_in = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        Reset = 1'b0;

        // scroll, wrap and score with a single start pulse
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            gap1_in = 16'($urandom_range(50, 200));
            gap2_in = 16'($urandom_range(50, 200));
            step();
        end

        // reset asserted mid-run
        mid_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) step();

        // hit on the very cycle of a tick
        for (int i = 0; i < 8 && m_presc != TD - 1; i++) step();
        check("presc_at_tick", m_presc, TD - 1);
        hit = 1'b1;
        step();
        hit = 1'b0;
        for (int i = 0; i < 10; i++) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();

        // saturation with both pipes scoring on one tick
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8 && m_presc != 0; i++) step();
        dut.r_pos1  = 16'd8;
        dut.r_pos2  = 16'd8;
        dut.r_score = 16'hFFFE;
        m_pos1 = 8; m_pos2 = 8; m_score = 16'hFFFE;
        for (int i = 0; i < TD + 2; i++) step();
        check("sat_score", score, 16'hFFFF);

        // randomized control and gap inputs
        for (int i = 0; i < 2500; i++) begin
            start   = ($urandom % 8) == 0;
            hit     = ($urandom % 150) == 0;
            restart = ($urandom % 6) == 0;
            gap1_in = 16'($urandom);
            gap2_in = 16'($urandom);
            if (($urandom % 1000) == 0) mid_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
